// File: rtl/umem_pkg.sv
// Shared definitions for the unified-memory arbiter.
// Requester IDs, return-tag layout and default starvation limit.
package umem_pkg;

  localparam int REQ_H = 0;
  localparam int REQ_D = 1;
  localparam int REQ_F = 2;
  localparam int NREQ  = 3;

  localparam int TAG_W = 2;
  localparam int STARVE_LIMIT_DEF = 8;

  typedef logic [TAG_W-1:0] owner_t;

  typedef struct packed {
    logic   valid;
    owner_t owner;
  } tag_t;

endpackage

// File: rtl/umem_prio.sv
// Fixed-priority grant encoder for the memory arbiter.
// Lock > starved fetch > host > data > fetch; one-hot result.
module umem_prio
  import umem_pkg::*;
(
  input  logic            en_i,
  input  logic            h_req_i,
  input  logic            d_req_i,
  input  logic            f_req_i,
  input  logic            h_lock_i,
  input  logic            starve_i,
  output logic [NREQ-1:0] gnt_o
);

  // Pick at most one winner; lock shuts out data and fetch entirely.
  always_comb begin
    gnt_o = '0;
    if (!en_i) begin
      gnt_o = '0;
    end else if (h_lock_i) begin
      gnt_o[REQ_H] = h_req_i;
    end else if (starve_i && f_req_i) begin
      gnt_o[REQ_F] = 1'b1;
    end else if (h_req_i) begin
      gnt_o[REQ_H] = 1'b1;
    end else if (d_req_i) begin
      gnt_o[REQ_D] = 1'b1;
    end else if (f_req_i) begin
      gnt_o[REQ_F] = 1'b1;
    end
  end

endmodule

// File: rtl/umem_arbiter.sv
// Single-port memory arbiter: host loader, MM data, IF fetch.
// Grants combinationally, tags reads to route returned data.
module umem_arbiter
  import umem_pkg::*;
#(
  parameter int ADDR_WIDTH   = 30,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  h_req,
  input  logic                  d_req,
  input  logic                  f_req,
  input  logic                  h_we,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] h_addr,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [ADDR_WIDTH-1:0] f_addr,
  input  logic [DATA_WIDTH-1:0] h_wdata,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  input  logic                  h_lock,
  output logic                  h_gnt,
  output logic                  d_gnt,
  output logic                  f_gnt,
  output logic                  stall_if,
  output logic                  stall_mm,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_in,
  output logic                  mem_we,
  input  logic [DATA_WIDTH-1:0] mem_out,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  h_rvalid,
  output logic                  d_rvalid,
  output logic                  f_rvalid
);

  localparam logic [7:0] LIM = 8'(STARVE_LIMIT);

  logic [NREQ-1:0] gnt;
  logic [7:0]      starve_q, starve_d;
  logic            starve;
  tag_t            tag_q, tag_d;

  assign starve = (starve_q == LIM);

  umem_prio u_prio (
    .en_i     (~rst),
    .h_req_i  (h_req),
    .d_req_i  (d_req),
    .f_req_i  (f_req),
    .h_lock_i (h_lock),
    .starve_i (starve),
    .gnt_o    (gnt)
  );

  assign h_gnt    = gnt[REQ_H];
  assign d_gnt    = gnt[REQ_D];
  assign f_gnt    = gnt[REQ_F];
  assign stall_if = f_req & ~f_gnt;
  assign stall_mm = d_req & ~d_gnt;

  // Count consecutive denied fetch cycles, saturating at the limit.
  always_comb begin
    starve_d = '0;
    if (f_req && !f_gnt) begin
      starve_d = starve ? starve_q : starve_q + 8'd1;
    end
  end

  // Steer the memory port from the winner and build the return tag.
  always_comb begin
    mem_addr = f_addr;
    mem_in   = '0;
    mem_we   = 1'b0;
    tag_d    = '0;
    unique case (1'b1)
      gnt[REQ_H]: begin
        mem_addr    = h_addr;
        mem_in      = h_wdata;
        mem_we      = h_we;
        tag_d.valid = ~h_we;
        tag_d.owner = owner_t'(REQ_H);
      end
      gnt[REQ_D]: begin
        mem_addr    = d_addr;
        mem_in      = d_wdata;
        mem_we      = d_we;
        tag_d.valid = ~d_we;
        tag_d.owner = owner_t'(REQ_D);
      end
      gnt[REQ_F]: begin
        tag_d.valid = 1'b1;
        tag_d.owner = owner_t'(REQ_F);
      end
      default: begin
      end
    endcase
  end

  // State registers: starvation counter and one-deep return tag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_q <= '0;
      tag_q    <= '0;
    end else begin
      starve_q <= starve_d;
      tag_q    <= tag_d;
    end
  end

  assign rdata    = mem_out;
  assign h_rvalid = tag_q.valid && (tag_q.owner == owner_t'(REQ_H));
  assign d_rvalid = tag_q.valid && (tag_q.owner == owner_t'(REQ_D));
  assign f_rvalid = tag_q.valid && (tag_q.owner == owner_t'(REQ_F));

endmodule

// File: tb/tb_umem_arbiter.sv
// Testbench for umem_arbiter with a word memory and reference model.
// Table vectors, directed sequences, then randomized traffic.
module tb_umem_arbiter;

  localparam int AW  = 30;
  localparam int DW  = 32;
  localparam int LIM = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          h_req, d_req, f_req, h_we, d_we, h_lock;
  logic [AW-1:0] h_addr, d_addr, f_addr;
  logic [DW-1:0] h_wdata, d_wdata;
  logic          h_gnt, d_gnt, f_gnt, stall_if, stall_mm;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_in, mem_out, rdata;
  logic          mem_we, h_rvalid, d_rvalid, f_rvalid;
  logic          init_mem;

  logic [DW-1:0] tmem [0:255];
  logic [DW-1:0] mm   [0:255];

  int n_chk  = 0;
  int n_fail = 0;
  int scnt;
  int pend_own;
  logic [DW-1:0] pend_data;

  logic s_hg, s_dg, s_fg, s_sif, s_smm, s_hrv, s_drv, s_frv;
  logic [DW-1:0] s_rdata;

  umem_arbiter #(
    .ADDR_WIDTH  (AW),
    .DATA_WIDTH  (DW),
    .STARVE_LIMIT(LIM)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .h_req    (h_req),
    .d_req    (d_req),
    .f_req    (f_req),
    .h_we     (h_we),
    .d_we     (d_we),
    .h_addr   (h_addr),
    .d_addr   (d_addr),
    .f_addr   (f_addr),
    .h_wdata  (h_wdata),
    .d_wdata  (d_wdata),
    .h_lock   (h_lock),
    .h_gnt    (h_gnt),
    .d_gnt    (d_gnt),
    .f_gnt    (f_gnt),
    .stall_if (stall_if),
    .stall_mm (stall_mm),
    .mem_addr (mem_addr),
    .mem_in   (mem_in),
    .mem_we   (mem_we),
    .mem_out  (mem_out),
    .rdata    (rdata),
    .h_rvalid (h_rvalid),
    .d_rvalid (d_rvalid),
    .f_rvalid (f_rvalid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 256; i++) tmem[i] <= 32'hA0 + i;
    end else if (mem_we) begin
      tmem[mem_addr[7:0]] <= mem_in;
    end
    mem_out <= tmem[mem_addr[7:0]];
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h @%0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic int pick();
    if (rst) return -1;
    if (h_lock) return h_req ? 0 : -1;
    if (scnt == LIM && f_req) return 2;
    if (h_req) return 0;
    if (d_req) return 1;
    if (f_req) return 2;
    return -1;
  endfunction

  task automatic model_reset();
    scnt     = 0;
    pend_own = -1;
  endtask

  // One clock: check outputs at negedge, advance model at posedge.
  task automatic step();
    int w, eo;
    logic ew;
    logic [AW-1:0] a;
    logic [DW-1:0] wd;
    @(negedge clk);
    w  = pick();
    ew = (w == 0) ? h_we : (w == 1) ? d_we : 1'b0;
    a  = (w == 0) ? h_addr : (w == 1) ? d_addr : f_addr;
    wd = (w == 0) ? h_wdata : d_wdata;
    eo = rst ? -1 : pend_own;
    s_hg = h_gnt; s_dg = d_gnt; s_fg = f_gnt;
    s_sif = stall_if; s_smm = stall_mm;
    s_hrv = h_rvalid; s_drv = d_rvalid; s_frv = f_rvalid;
    s_rdata = rdata;
    chk("h_gnt", 32'(h_gnt), 32'(w == 0));
    chk("d_gnt", 32'(d_gnt), 32'(w == 1));
    chk("f_gnt", 32'(f_gnt), 32'(w == 2));
    chk("stall_if", 32'(stall_if), 32'(f_req && w != 2));
    chk("stall_mm", 32'(stall_mm), 32'(d_req && w != 1));
    chk("mem_we", 32'(mem_we), 32'(ew));
    chk("mem_addr", 32'(mem_addr), 32'(a));
    if (ew) chk("mem_in", mem_in, wd);
    chk("h_rvalid", 32'(h_rvalid), 32'(eo == 0));
    chk("d_rvalid", 32'(d_rvalid), 32'(eo == 1));
    chk("f_rvalid", 32'(f_rvalid), 32'(eo == 2));
    if (eo >= 0) chk("rdata", rdata, pend_data);
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      if (f_req && w != 2) scnt = (scnt < LIM) ? scnt + 1 : scnt;
      else scnt = 0;
      pend_own = -1;
      if (w >= 0 && !ew) begin
        pend_own  = w;
        pend_data = mm[a[7:0]];
      end
      if (ew) mm[a[7:0]] = wd;
    end
    #1;
  endtask

  task automatic idle();
    h_req = 0; d_req = 0; f_req = 0;
    h_we = 0; d_we = 0; h_lock = 0;
    h_addr = '0; d_addr = '0; f_addr = '0;
    h_wdata = '0; d_wdata = '0;
  endtask

  typedef struct {
    logic       r, hl, h, d, f;
    logic [4:0] exp;
  } vec_t;

  vec_t vt [10];

  initial begin
    vt[0] = '{1, 0, 1, 1, 1, 5'b00011};
    vt[1] = '{0, 0, 0, 0, 0, 5'b00000};
    vt[2] = '{0, 0, 1, 1, 1, 5'b10011};
    vt[3] = '{0, 0, 0, 1, 1, 5'b01010};
    vt[4] = '{0, 0, 0, 0, 1, 5'b00100};
    vt[5] = '{0, 0, 1, 0, 0, 5'b10000};
    vt[6] = '{0, 1, 0, 1, 1, 5'b00011};
    vt[7] = '{0, 1, 1, 0, 1, 5'b10010};
    vt[8] = '{0, 0, 0, 1, 0, 5'b01000};
    vt[9] = '{0, 0, 1, 1, 0, 5'b10001};

    idle();
    rst = 1;
    init_mem = 1;
    for (int i = 0; i < 256; i++) mm[i] = 32'hA0 + i;
    model_reset();
    @(posedge clk);
    #1 init_mem = 0;

    // reset state
    step();
    chk("rst_starve", 32'(dut.starve_q), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    rst = 0;
    step();

    // priority table, counter cleared before each vector
    for (int i = 0; i < 10; i++) begin
      rst = 1; #1 rst = vt[i].r;
      h_lock = vt[i].hl; h_req = vt[i].h;
      d_req = vt[i].d; f_req = vt[i].f;
      @(negedge clk);
      chk($sformatf("vec%0d", i),
          32'({h_gnt, d_gnt, f_gnt, stall_if, stall_mm}),
          32'(vt[i].exp));
      @(posedge clk);
      #1;
    end
    idle();
    rst = 1;
    step();
    rst = 0;
    step();

    // fetch-only stream
    f_req = 1; f_addr = 0;
    step(); chk("fs_gnt0", 32'(s_fg), 1);
    f_addr = 1;
    step(); chk("fs_gnt1", 32'(s_fg), 1);
    chk("fs_rd0", s_rdata, 32'hA0); chk("fs_rv0", 32'(s_frv), 1);
    f_addr = 2;
    step(); chk("fs_gnt2", 32'(s_fg), 1);
    chk("fs_rd1", s_rdata, 32'hA1);
    f_req = 0;
    step(); chk("fs_rd2", s_rdata, 32'hA2);
    chk("fs_rv2", 32'(s_frv), 1);

    // all three requesting
    h_req = 1; h_we = 1; h_addr = 4; h_wdata = 32'h55;
    d_req = 1; d_addr = 4; f_req = 1; f_addr = 8;
    step(); chk("a3_h", 32'(s_hg), 1);
    h_req = 0; h_we = 0;
    step(); chk("a3_d", 32'(s_dg), 1);
    d_req = 0;
    step(); chk("a3_f", 32'(s_fg), 1);
    chk("a3_drv", 32'(s_drv), 1);
    chk("a3_rdata", s_rdata, 32'h55);
    idle();
    step();

    // starvation guard
    d_req = 1; d_addr = 1; f_req = 1; f_addr = 2;
    for (int c = 0; c < 3; c++) begin
      step(); chk($sformatf("sv_d%0d", c), 32'(s_dg), 1);
    end
    chk("sv_sat", 32'(dut.starve_q), LIM);
    step(); chk("sv_f", 32'(s_fg), 1);
    chk("sv_smm", 32'(s_smm), 1);
    chk("sv_clr", 32'(dut.starve_q), 0);
    idle();
    step();

    // host lock
    h_lock = 1; f_req = 1; d_req = 1; f_addr = 3; d_addr = 6;
    for (int c = 0; c < 10; c++) begin
      step();
      chk("lk_fgnt", 32'(s_fg), 0);
      chk("lk_sif", 32'(s_sif), 1);
    end
    h_lock = 0;
    step(); chk("lk_after", 32'(s_fg), 1);
    idle();
    step();

    // reset between a data read grant and its return
    d_req = 1; d_addr = 5; f_req = 1;
    step(); chk("rr_gnt", 32'(s_dg), 1);
    idle();
    chk("rr_pend", 32'(d_rvalid), 1);
    #2 rst = 1;
    #1;
    chk("rr_drv", 32'(d_rvalid), 0);
    chk("rr_cnt", 32'(dut.starve_q), 0);
    chk("rr_we", 32'(mem_we), 0);
    model_reset();
    step();
    rst = 0;
    step(); chk("rr_post0", 32'(s_drv), 0);
    step(); chk("rr_post1", 32'(s_drv), 0);

    // randomized traffic
    for (int c = 0; c < 400; c++) begin
      rst     = ($urandom % 64) == 0;
      h_lock  = ($urandom % 8) == 0;
      h_req   = $urandom % 2;
      d_req   = $urandom % 2;
      f_req   = ($urandom % 4) != 0;
      h_we    = $urandom % 2;
      d_we    = $urandom % 2;
      h_addr  = AW'($urandom % 32);
      d_addr  = AW'($urandom % 32);
      f_addr  = AW'($urandom % 32);
      h_wdata = $urandom;
      d_wdata = $urandom;
      step();
    end
    idle();
    rst = 0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
